// File: rtl/mem_arbiter_pkg.sv
// Shared types for the ICache/DCache-to-memory arbiter: FSM states, grant owner
// and access-size encodings used by the cache front-ends.
package mem_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      I_REQ  = 3'd1,
      I_WAIT = 3'd2,
      D_REQ  = 3'd3,
      D_WAIT = 3'd4,
      RESP   = 3'd5
   } arb_state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } arb_owner_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   // The reserved encoding 3 is issued to memory as a full word.
   function automatic logic [1:0] norm_size(input logic [1:0] s);
      case (s)
         SIZE_BYTE, SIZE_HALF: return s;
         default:              return SIZE_WORD;
      endcase
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (inst/data) to one-slave memory arbiter, one transaction in flight; grant->data_ok is 3 cycles minimum.
// Stalls on mem_addr_ok with mem_* held stable; new requests are only accepted in IDLE.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic              inst_cancel,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,

   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,

   output logic              mem_req,
   output logic              mem_wr,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_addr_ok,
   input  logic              mem_data_ok,
   input  logic [DATA_W-1:0] mem_rdata
);

   arb_state_t        state;
   arb_owner_t        last_grant;
   arb_owner_t        owner;
   logic              cancel_pending;
   logic              grant_inst;
   logic              grant_data;
   logic              cancel_hit;
   logic              inst_ok_q;
   logic              data_ok_q;
   logic [DATA_W-1:0] resp_data;

   // Data has priority under contention unless it won the previous grant.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (state == IDLE && !rst) begin
         if (inst_req && data_req) begin
            if (last_grant == OWN_DATA) grant_inst = 1'b1;
            else                        grant_data = 1'b1;
         end else begin
            grant_inst = inst_req;
            grant_data = data_req;
         end
      end
   end

   assign cancel_hit = inst_cancel &&
                       (state == I_REQ || state == I_WAIT || grant_inst ||
                        (state == RESP && owner == OWN_INST));

   assign inst_addr_ok = grant_inst;
   assign data_addr_ok = grant_data;
   // A flush landing in the response cycle itself must still swallow the pulse.
   assign inst_data_ok = inst_ok_q & ~inst_cancel;
   assign data_data_ok = data_ok_q;
   assign inst_rdata   = resp_data;
   assign data_rdata   = resp_data;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         last_grant     <= OWN_INST;
         owner          <= OWN_INST;
         cancel_pending <= 1'b0;
         mem_req        <= 1'b0;
         inst_ok_q      <= 1'b0;
         data_ok_q      <= 1'b0;
      end else begin
         inst_ok_q <= 1'b0;
         data_ok_q <= 1'b0;

         if (state == RESP)   cancel_pending <= 1'b0;
         else if (cancel_hit) cancel_pending <= 1'b1;

         case (state)
            IDLE: begin
               if (grant_data) begin
                  state      <= D_REQ;
                  last_grant <= OWN_DATA;
                  mem_req    <= 1'b1;
               end else if (grant_inst) begin
                  state      <= I_REQ;
                  last_grant <= OWN_INST;
                  mem_req    <= 1'b1;
               end
            end
            I_REQ: begin
               if (mem_addr_ok) begin
                  state   <= I_WAIT;
                  mem_req <= 1'b0;
               end
            end
            D_REQ: begin
               if (mem_addr_ok) begin
                  state   <= D_WAIT;
                  mem_req <= 1'b0;
               end
            end
            I_WAIT: begin
               if (mem_data_ok) begin
                  state     <= RESP;
                  owner     <= OWN_INST;
                  inst_ok_q <= !(cancel_pending || inst_cancel);
               end
            end
            D_WAIT: begin
               if (mem_data_ok) begin
                  state     <= RESP;
                  owner     <= OWN_DATA;
                  data_ok_q <= 1'b1;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Request register: mem_* are driven straight from here and hold until the next grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_wr    <= 1'b0;
         mem_size  <= SIZE_BYTE;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else if (grant_data) begin
         mem_wr    <= data_wr;
         mem_size  <= norm_size(data_size);
         mem_addr  <= data_addr;
         mem_wdata <= data_wdata;
      end else if (grant_inst) begin
         mem_wr    <= 1'b0;
         mem_size  <= SIZE_WORD;
         mem_addr  <= inst_addr;
         mem_wdata <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         resp_data <= '0;
      else if ((state == I_WAIT || state == D_WAIT) && mem_data_ok)
         resp_data <= mem_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model of grant order,
// memory handshakes, response timing, cancel and reset.
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          inst_req = 1'b0, inst_cancel = 1'b0;
   logic [AW-1:0] inst_addr = '0;
   logic          inst_addr_ok, inst_data_ok;
   logic [DW-1:0] inst_rdata;
   logic          data_req = 1'b0, data_wr = 1'b0;
   logic [1:0]    data_size = 2'd0;
   logic [AW-1:0] data_addr = '0;
   logic [DW-1:0] data_wdata = '0;
   logic          data_addr_ok, data_data_ok;
   logic [DW-1:0] data_rdata;
   logic          mem_req, mem_wr;
   logic [1:0]    mem_size;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
   logic [DW-1:0] mem_rdata = '0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   int total = 0;
   int bad   = 0;
   int cyc;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Model of the one transaction in flight, tracked by the cycle numbers of its events.
   bit            txn_act, t_data, t_wr, t_cancel, last_data, rst_prev, late_dok;
   logic [1:0]    t_size;
   logic [AW-1:0] t_addr;
   logic [DW-1:0] t_wdata, t_rdata;
   int            g_cyc, a_cyc, d_cyc, aw_left, dw_left, mode;
   bit            i_hold, d_hold;
   bit            exp_gi, exp_gd, exp_req, exp_dok, exp_i, exp_d;

   initial begin
      txn_act = 0; last_data = 0; late_dok = 0; i_hold = 0; d_hold = 0;
      g_cyc = 0; a_cyc = -1; d_cyc = -1; aw_left = 0; dw_left = 0;
      t_data = 0; t_wr = 0; t_cancel = 0; t_size = '0; t_addr = '0; t_wdata = '0; t_rdata = '0;

      for (cyc = 1; cyc <= 6000; cyc++) begin
         @(posedge clk);
         #1;
         mode     = (cyc < 2000) ? 0 : (cyc < 4000) ? 1 : 2;
         rst_prev = rst;
         rst      = (cyc <= 1) || ($urandom_range(0, 199) == 0);

         // Arbiter is free again two cycles after the memory response.
         if (txn_act && d_cyc >= 0 && cyc >= d_cyc + 2) txn_act = 0;

         if (!i_hold && $urandom_range(0, 99) < ((mode == 1) ? 100 : 35)) begin
            i_hold    = 1;
            inst_addr = $urandom & ~32'h3;
         end
         if (!d_hold && $urandom_range(0, 99) < ((mode == 1) ? 100 : 35)) begin
            d_hold     = 1;
            data_wr    = $urandom_range(0, 1);
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = $urandom;
            data_wdata = $urandom;
         end
         inst_req    = i_hold;
         data_req    = d_hold;
         inst_cancel = ($urandom_range(0, 15) == 0);

         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         mem_rdata   = $urandom;
         if (txn_act && cyc > g_cyc && a_cyc < 0) begin
            if (aw_left == 0) mem_addr_ok = 1'b1;
            else aw_left--;
         end else if (txn_act && a_cyc >= 0 && d_cyc < 0 && cyc > a_cyc) begin
            if (dw_left == 0) mem_data_ok = 1'b1;
            else dw_left--;
         end else begin
            mem_data_ok = ($urandom_range(0, 7) == 0);
         end
         if (late_dok) begin
            mem_data_ok = 1'b1;
            late_dok    = 0;
         end

         @(negedge clk);
         exp_gi = 0;
         exp_gd = 0;
         if (!rst && !txn_act) begin
            if (inst_req && data_req) begin
               if (last_data) exp_gi = 1;
               else           exp_gd = 1;
            end else begin
               exp_gi = inst_req;
               exp_gd = data_req;
            end
         end
         check("addr_ok", {inst_addr_ok, data_addr_ok}, {exp_gi, exp_gd});

         if (rst) begin
            if (txn_act && a_cyc >= 0 && d_cyc < 0) late_dok = 1;
            txn_act   = 0;
            last_data = 0;
         end else begin
            if (rst_prev) begin
               check("rst_mem", {mem_req, mem_wr, mem_size, mem_addr, mem_wdata}, '0);
               check("rst_rdata", {inst_rdata, data_rdata}, '0);
            end

            exp_req = txn_act && cyc > g_cyc && a_cyc < 0;
            check("mem_req", mem_req, exp_req);
            if (exp_req) begin
               if (t_data)
                  check("mem_bus_d", {mem_wr, mem_size, mem_addr, mem_wdata},
                        {t_wr, t_size, t_addr, t_wdata});
               else
                  check("mem_bus_i", {mem_wr, mem_size, mem_addr}, {1'b0, 2'd2, t_addr});
            end

            if (txn_act && !t_data && inst_cancel && cyc > g_cyc && (d_cyc < 0 || cyc <= d_cyc + 1))
               t_cancel = 1;
            exp_dok = txn_act && d_cyc >= 0 && cyc == d_cyc + 1;
            exp_i   = exp_dok && !t_data && !t_cancel;
            exp_d   = exp_dok && t_data;
            check("data_ok", {inst_data_ok, data_data_ok}, {exp_i, exp_d});
            if (exp_i) check("inst_rdata", inst_rdata, t_rdata);
            if (exp_d && !t_wr) check("data_rdata", data_rdata, t_rdata);

            if (exp_req && mem_addr_ok) a_cyc = cyc;
            if (txn_act && a_cyc >= 0 && a_cyc < cyc && d_cyc < 0 && mem_data_ok) begin
               d_cyc   = cyc;
               t_rdata = mem_rdata;
            end

            if (exp_gi || exp_gd) begin
               txn_act   = 1;
               t_data    = exp_gd;
               g_cyc     = cyc;
               a_cyc     = -1;
               d_cyc     = -1;
               last_data = exp_gd;
               t_cancel  = exp_gi && inst_cancel;
               aw_left   = (mode == 1) ? 0 : $urandom_range(0, (mode == 2) ? 4 : 2);
               dw_left   = (mode == 1) ? 0 : $urandom_range(0, (mode == 2) ? 3 : 2);
               if (exp_gd) begin
                  t_wr    = data_wr;
                  t_size  = data_size;
                  t_addr  = data_addr;
                  t_wdata = data_wdata;
                  d_hold  = 0;
               end else begin
                  t_wr    = 0;
                  t_size  = 2'd2;
                  t_addr  = inst_addr;
                  t_wdata = '0;
                  i_hold  = 0;
               end
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
